// File: rtl/msk_unmask_stream.sv
// msk_unmask_stream: recombines a d-share Boolean sharing into its plain word.
// One share is XORed into a registered accumulator per cycle, in index order.
// Stored shares are zeroized as they are consumed.
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_shares/in_valid   d*W-bit sharing (share i at [i*W +: W]) and its valid
//   in_ready             high in IDLE only
//   out_data/out_valid   recombined word (zero unless valid), valid in HOLD
//   out_ready            consumer acceptance, honoured in HOLD only
//   busy                 high in ACC or HOLD
module msk_unmask_stream #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [d*W-1:0] in_shares,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  // Invalid-instance guard: share count must lie in 2..8.
  generate
    if (d < 2 || d > 8) begin : g_bad_d
      $fatal(1, "msk_unmask_stream: parameter d must be in 2..8");
    end
  endgenerate

  localparam int unsigned CW = (d > 1) ? $clog2(d) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  // Slot 0 is never written: share 0 goes straight into the accumulator.
  logic [W-1:0]    sh_q [d];
  logic [W-1:0]    sh_d [d];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int unsigned i = 1; i < d; i++) begin
            sh_d[i] = in_shares[i*W +: W];
          end
          acc_d   = in_shares[W-1:0];
          cnt_d   = CW'(1);
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d        = acc_q ^ sh_q[cnt_q];
        sh_d[cnt_q]  = '0;
        if (cnt_q == CW'(d - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        acc_d   = '0;
        for (int unsigned i = 0; i < d; i++) begin
          sh_d[i] = '0;
        end
      end
    endcase
  end

  // State and share registers; reset also zeroizes all share storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      for (int unsigned i = 0; i < d; i++) begin
        sh_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      for (int unsigned i = 0; i < d; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

  // Outputs decode registered state only; out_data is gated to zero outside HOLD.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = (state_q == S_HOLD) ? acc_q : '0;

endmodule

// File: tb/tb_msk_unmask_stream.sv
module tb_msk_unmask_stream;

  logic clk;
  int   n_cmp;
  int   n_bad;

  // d=2 instance
  logic        rst2_n, in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [15:0] in_shares2;
  logic [7:0]  out_data2;
  // d=3 instance
  logic        rst3_n, in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [23:0] in_shares3;
  logic [7:0]  out_data3;
  // d=4 instance
  logic        rst4_n, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [31:0] in_shares4;
  logic [7:0]  out_data4;

  msk_unmask_stream #(.d(2), .W(8)) u2 (
    .clk(clk), .rst_n(rst2_n), .in_shares(in_shares2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .busy(busy2));

  msk_unmask_stream #(.d(3), .W(8)) u3 (
    .clk(clk), .rst_n(rst3_n), .in_shares(in_shares3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .busy(busy3));

  msk_unmask_stream #(.d(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst4_n), .in_shares(in_shares4), .in_valid(in_valid4),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; observe 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {in_ready, out_valid, busy, out_data}.
  task automatic test_reset();
    rst2_n = 1'b0; rst3_n = 1'b0; rst4_n = 1'b0;
    in_valid2 = 1'b1; in_valid3 = 1'b1; in_valid4 = 1'b1;
    in_shares2 = 16'hFFFF; in_shares3 = 24'hFFFFFF; in_shares4 = 32'hFFFFFFFF;
    out_ready2 = 1'b1; out_ready3 = 1'b1; out_ready4 = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({in_ready2, out_valid2, busy2, out_data2} !== 11'b100_0000_0000) begin
      n_bad++; $display("FAIL reset_d2 got %b want %b", {in_ready2, out_valid2, busy2, out_data2}, 11'b100_0000_0000);
    end
    n_cmp++;
    if ({in_ready3, out_valid3, busy3, out_data3} !== 11'b100_0000_0000) begin
      n_bad++; $display("FAIL reset_d3 got %b want %b", {in_ready3, out_valid3, busy3, out_data3}, 11'b100_0000_0000);
    end
    n_cmp++;
    if ({in_ready4, out_valid4, busy4, out_data4, u4.acc_q} !== 19'b100_0000_0000_0000_0000) begin
      n_bad++; $display("FAIL reset_d4 got %b want %b", {in_ready4, out_valid4, busy4, out_data4, u4.acc_q}, 19'b100_0000_0000_0000_0000);
    end
    in_valid2 = 1'b0; in_valid3 = 1'b0; in_valid4 = 1'b0;
    in_shares2 = '0; in_shares3 = '0; in_shares4 = '0;
    rst2_n = 1'b1; rst3_n = 1'b1; rst4_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_d2();
    logic [10:0] exp [4];
    exp[0] = {1'b1, 1'b0, 1'b0, 8'h00};
    exp[1] = {1'b0, 1'b0, 1'b1, 8'h00};
    exp[2] = {1'b0, 1'b1, 1'b1, 8'h66};
    exp[3] = {1'b1, 1'b0, 1'b0, 8'h00};
    out_ready2 = 1'b1;
    in_shares2 = {8'h3C, 8'h5A};
    in_valid2  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({in_ready2, out_valid2, busy2, out_data2} !== exp[c]) begin
        n_bad++; $display("FAIL basic_d2 cycle %0d got %h want %h", c, {in_ready2, out_valid2, busy2, out_data2}, exp[c]);
      end
      tick();
      in_valid2  = 1'b0;
      in_shares2 = '0;
    end
  endtask

  task automatic test_d3();
    logic [23:0] sh [2];
    logic [7:0]  res [2];
    sh[0] = {8'hF0, 8'h0F, 8'hFF}; res[0] = 8'h00;
    sh[1] = {8'h01, 8'h02, 8'h04}; res[1] = 8'h07;
    out_ready3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_shares3 = sh[k];
      in_valid3  = 1'b1;
      tick();
      in_valid3  = 1'b0;
      in_shares3 = '0;
      n_cmp++;
      if (out_valid3 !== 1'b0 || out_data3 !== 8'h00) begin
        n_bad++; $display("FAIL d3_cycle1 run %0d got v=%b d=%h want v=0 d=00", k, out_valid3, out_data3);
      end
      tick();
      n_cmp++;
      if ({u3.sh_q[1], u3.sh_q[2], out_valid3} !== {8'h00, sh[k][23:16], 1'b0}) begin
        n_bad++; $display("FAIL d3_cycle2 run %0d got %h want %h", k, {u3.sh_q[1], u3.sh_q[2], out_valid3}, {8'h00, sh[k][23:16], 1'b0});
      end
      tick();
      n_cmp++;
      if ({out_valid3, out_data3} !== {1'b1, res[k]}) begin
        n_bad++; $display("FAIL d3_result run %0d got %h want %h", k, {out_valid3, out_data3}, {1'b1, res[k]});
      end
      n_cmp++;
      if ({u3.sh_q[1], u3.sh_q[2]} !== 16'h0000) begin
        n_bad++; $display("FAIL d3_zeroize run %0d got %h want 0000", k, {u3.sh_q[1], u3.sh_q[2]});
      end
      tick();
      n_cmp++;
      if ({in_ready3, out_valid3, out_data3} !== {1'b1, 1'b0, 8'h00}) begin
        n_bad++; $display("FAIL d3_idle run %0d got %h want %h", k, {in_ready3, out_valid3, out_data3}, {1'b1, 1'b0, 8'h00});
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready2 = 1'b0;
    in_shares2 = {8'h3C, 8'h5A};
    in_valid2  = 1'b1;
    tick();
    in_valid2  = 1'b0;
    in_shares2 = 16'hA5A5;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({in_ready2, out_valid2, out_data2} !== {1'b0, 1'b1, 8'h66}) begin
        n_bad++; $display("FAIL bp_hold cycle %0d got %h want %h", c, {in_ready2, out_valid2, out_data2}, {1'b0, 1'b1, 8'h66});
      end
      tick();
    end
    out_ready2 = 1'b1;
    n_cmp++;
    if ({out_valid2, out_data2} !== {1'b1, 8'h66}) begin
      n_bad++; $display("FAIL bp_release got %h want %h", {out_valid2, out_data2}, {1'b1, 8'h66});
    end
    tick();
    n_cmp++;
    if ({in_ready2, out_valid2, busy2, out_data2, u2.acc_q} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_bad++; $display("FAIL bp_idle got %h want %h", {in_ready2, out_valid2, busy2, out_data2, u2.acc_q}, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
    end
    in_shares2 = '0;
  endtask

  task automatic test_ignored_input();
    logic [15:0] sh  [6];
    logic [8:0]  exp [6];
    sh[0] = {8'h11, 8'h22}; exp[0] = {1'b0, 8'h00};
    sh[1] = {8'hFF, 8'h00}; exp[1] = {1'b0, 8'h00};
    sh[2] = {8'h0F, 8'hF0}; exp[2] = {1'b1, 8'h33};
    sh[3] = {8'hAA, 8'h55}; exp[3] = {1'b0, 8'h00};
    sh[4] = {8'h12, 8'h34}; exp[4] = {1'b0, 8'h00};
    sh[5] = {8'h00, 8'h00}; exp[5] = {1'b1, 8'hFF};
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_shares2 = sh[c];
      n_cmp++;
      if ({out_valid2, out_data2} !== exp[c]) begin
        n_bad++; $display("FAIL ignored_input cycle %0d got %h want %h", c, {out_valid2, out_data2}, exp[c]);
      end
      tick();
    end
    in_valid2  = 1'b0;
    in_shares2 = '0;
    tick();
  endtask

  task automatic test_reset_mid_acc();
    out_ready4 = 1'b1;
    in_shares4 = {8'h01, 8'h02, 8'h04, 8'h08};
    in_valid4  = 1'b1;
    tick();
    in_valid4  = 1'b0;
    tick();
    rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
    n_cmp++;
    if ({in_ready4, out_valid4, busy4, out_data4, u4.acc_q} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_bad++; $display("FAIL rst_mid_flags got %h want %h", {in_ready4, out_valid4, busy4, out_data4, u4.acc_q}, {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
    end
    n_cmp++;
    if ({u4.sh_q[1], u4.sh_q[2], u4.sh_q[3]} !== 24'h000000) begin
      n_bad++; $display("FAIL rst_mid_shares got %h want 000000", {u4.sh_q[1], u4.sh_q[2], u4.sh_q[3]});
    end
    in_shares4 = {8'h11, 8'h22, 8'h44, 8'h88};
    in_valid4  = 1'b1;
    tick();
    in_valid4  = 1'b0;
    in_shares4 = '0;
    for (int c = 1; c < 4; c++) begin
      n_cmp++;
      if ({out_valid4, out_data4, busy4} !== {1'b0, 8'h00, 1'b1}) begin
        n_bad++; $display("FAIL rst_mid_acc cycle %0d got %h want %h", c, {out_valid4, out_data4, busy4}, {1'b0, 8'h00, 1'b1});
      end
      tick();
    end
    n_cmp++;
    if ({out_valid4, out_data4} !== {1'b1, 8'hFF}) begin
      n_bad++; $display("FAIL rst_mid_result got %h want %h", {out_valid4, out_data4}, {1'b1, 8'hFF});
    end
    tick();
    n_cmp++;
    if ({in_ready4, out_valid4, out_data4} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL rst_mid_idle got %h want %h", {in_ready4, out_valid4, out_data4}, {1'b1, 1'b0, 8'h00});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_d2();
    test_d3();
    test_backpressure();
    test_ignored_input();
    test_reset_mid_acc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msk_unmask_stream.md
Name: msk_unmask_stream

Overview:
- Terminal decoder for masked datapaths. It accepts a d-share Boolean sharing of a W-bit word over a valid/ready handshake and recombines it into the plain value.
- Recombination is serial: one share is XORed per cycle, and every intermediate value is registered.
- It sits at the output boundary of MSK gadget pipelines, for example after 2-share AND gadgets with latency 2, and hands cleartext to unmasked logic.
- Share storage is zeroized after use, and out_data is forced to zero whenever out_valid is low.

Parameters:
- d, 2, number of shares; legal range 2..8. Any other value must fail elaboration through an invalid-instance guard.
- W, 8, width in bits of one share and of the recombined word.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_shares  input  d*W  sharing; share i occupies bits [i*W +: W]
- in_valid  input  1  in_shares is valid
- in_ready  output  1  block can accept a sharing
- out_data  output  W  recombined word; zero when out_valid=0
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in ACC or HOLD

Behaviour:
- Reset (rst_n=0 at a clk edge), effective from that edge:
  - state=IDLE, cnt=0, acc=0.
  - All share registers are set to 0.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset dominates any simultaneous handshake.
- FSM states: IDLE, ACC, HOLD. in_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE, when in_valid=1 at an edge (handshake):
  - Capture share registers sh[1..d-1] from in_shares.
  - acc <= share 0; cnt <= 1; go to ACC.
  - Share 0 is not stored separately.
- IDLE with in_valid=0: hold state; registers unchanged (all zero).
- ACC, at each edge:
  - acc <= acc ^ sh[cnt]; sh[cnt] <= 0; cnt <= cnt+1.
  - If cnt==d-1, go to HOLD instead and set cnt <= 0.
  - ACC lasts exactly d-1 cycles.
- HOLD:
  - out_valid=1, out_data=acc; acc and out_data are stable.
  - If out_ready=1 at an edge: acc <= 0 and go to IDLE.
  - If out_ready=0: remain in HOLD indefinitely with no change.
- Latency: sharing accepted in cycle t, so out_valid is first high in cycle t+d.
- Throughput: one word per d+1 cycles when out_ready is held high. No overlap; in_ready is low during ACC and HOLD.
- in_valid and in_shares are ignored outside IDLE. No capture, and no change to acc or sh.
- out_ready is ignored outside HOLD.
- Arithmetic: bitwise XOR only; acc width is W; no carries.
- cnt width is clog2(d) bits, minimum 1.
- No combinational path from in_shares to any output. out_data is driven only from acc, gated by (state==HOLD).
- Shares are XORed strictly in index order 0,1,...,d-1, one per cycle. Two input shares are never combined in the same cycle except acc with one stored share.
- Reset mid-operation (ACC or HOLD): the partially or fully recombined word is discarded. Zeroization is as in the reset bullet. The next cycle has in_ready=1.

Test Plan:
- d=2, W=8. in_shares={0x3C,0x5A} (share1=0x3C, share0=0x5A), in_valid pulsed in cycle 0, out_ready=1 → in_ready=0 in cycles 1-2; out_valid=1 and out_data=0x66 only in cycle 2; in_ready=1 in cycle 3; out_data=0x00 in all other cycles.
- d=3, W=8. Shares {0xF0,0x0F,0xFF} → out_valid first high in cycle 3 with out_data=0x00. Repeat with {0x01,0x02,0x04} → 0x07. Check that the sh registers read 0 once consumed.
- Backpressure, d=2. Hold out_ready=0 for 5 cycles after out_valid rises → out_valid stays 1 and out_data stays 0x66. Raise out_ready → the handshake completes in one cycle, then IDLE.
- Ignored input, d=2. Hold in_valid=1 continuously with changing shares → the next sharing is captured only in the IDLE cycle after the previous output handshake. Each word equals the XOR of the shares present in its capture cycle.
- Reset mid-ACC, d=4. Drop rst_n in cycle 2 after accept → from the next cycle in_ready=1, out_valid=0, out_data=0, acc=0, all sh=0. A fresh sharing {0x11,0x22,0x44,0x88} then yields 0xFF, 4 cycles after its acceptance.
